// File: rtl/platform_field_if.sv
// Bundle of frame/pixel/ball signals between the video pipeline and the platform store.
// The master drives the frame strobe and queries; the slave (platform_field) answers.
interface platform_field_if;
  logic       frame_clk;
  logic [9:0] scroll_amt;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] BallX;
  logic [9:0] BallBottom;
  logic       platform_on;
  logic [4:0] plat_idx;
  logic       land;
  logic       update_done;

  modport master (
    output frame_clk, scroll_amt, DrawX, DrawY, BallX, BallBottom,
    input  platform_on, plat_idx, land, update_done
  );

  modport slave (
    input  frame_clk, scroll_amt, DrawX, DrawY, BallX, BallBottom,
    output platform_on, plat_idx, land, update_done
  );
endinterface

// File: rtl/platform_field.sv
// Platform slot store for Doodle-Jump: scrolls/respawns NUM_PLAT slots once per frame and answers
// pixel and ball-landing queries. Define PLATFORM_FIELD_MOVING_EN to make odd slots drift sideways.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for a frame tick (or a pending one)
// S_UPDATE | scrolling slot idx_q, one slot per clock
// S_DONE   | all slots written; raises update_done next cycle
module platform_field #(
  parameter int         NUM_PLAT  = 16,
  parameter int         PLAT_HW   = 4,
  parameter int         PLAT_HH   = 4,
  parameter int         SCREEN_W  = 640,
  parameter int         SCREEN_H  = 480,
  parameter int         SPACING   = 30,
  parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
  input logic              Clk,
  input logic              Reset,
  platform_field_if.slave  bus
);

  localparam int RANGE     = SCREEN_W - 2 * PLAT_HW;
  localparam int RESPAWN_Y = SCREEN_H + PLAT_HH;
  localparam int WRAP      = NUM_PLAT * SPACING;
  localparam int IDX_W     = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [9:0]         amt_q, amt_d;
  logic               pend_q, pend_d;
  logic [9:0]         lfsr_q, lfsr_d;
  logic signed [10:0] y_q [NUM_PLAT];
  logic signed [10:0] y_d [NUM_PLAT];
  logic [9:0]         x_q [NUM_PLAT];
  logic [9:0]         x_d [NUM_PLAT];

  logic sync1_q, sync2_q, prev_q;
  logic frame_tick;

  logic       on_q, on_d;
  logic [4:0] pidx_q, pidx_d;
  logic       land_q, land_d;
  logic       done_q, done_d;

  logic [10:0] cur_y;
  logic [11:0] ny;
  logic        respawn;
  logic [9:0]  lfsr_mod;
  logic [9:0]  lfsr_step;

`ifdef PLATFORM_FIELD_MOVING_EN
  localparam int X_HI = SCREEN_W - 1 - PLAT_HW;
  logic [NUM_PLAT-1:0] dir_q, dir_d;
  logic [9:0]          cur_x;
  assign cur_x = x_q[idx_q];
`endif

  // frame_clk comes from another domain: two-flop sync, then rising-edge detect
  assign frame_tick = sync2_q & ~prev_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= bus.frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      amt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      amt_q   <= amt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    amt_d   = amt_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_tick || pend_q) begin
          amt_d   = (bus.scroll_amt > 10'(SPACING)) ? 10'(SPACING) : bus.scroll_amt;
          idx_d   = '0;
          pend_d  = 1'b0;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (frame_tick) pend_d = 1'b1;
        if (idx_q == IDX_W'(NUM_PLAT - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (frame_tick) pend_d = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slot datapath: only the slot at idx_q is rewritten during S_UPDATE
  assign cur_y     = y_q[idx_q];
  assign ny        = {cur_y[10], cur_y} + {2'b00, amt_q};
  assign respawn   = (state_q == S_UPDATE) && ($signed(ny) >= $signed(12'(RESPAWN_Y)));
  assign lfsr_mod  = (lfsr_q >= 10'(RANGE)) ? (lfsr_q - 10'(RANGE)) : lfsr_q;
  assign lfsr_step = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

  always_comb begin
    y_d    = y_q;
    x_d    = x_q;
    lfsr_d = lfsr_q;
`ifdef PLATFORM_FIELD_MOVING_EN
    dir_d  = dir_q;
`endif
    if (state_q == S_UPDATE) begin
      if (respawn) begin
        y_d[idx_q] = 11'(ny - 12'(WRAP));
        x_d[idx_q] = lfsr_mod + 10'(PLAT_HW);
        lfsr_d     = lfsr_step;
`ifdef PLATFORM_FIELD_MOVING_EN
        dir_d[idx_q] = 1'b1;
`endif
      end else begin
        y_d[idx_q] = ny[10:0];
`ifdef PLATFORM_FIELD_MOVING_EN
        if (idx_q[0]) begin
          if (dir_q[idx_q]) begin
            if (cur_x >= 10'(X_HI - 1)) begin
              x_d[idx_q]   = 10'(X_HI);
              dir_d[idx_q] = 1'b0;
            end else begin
              x_d[idx_q] = cur_x + 10'd1;
            end
          end else begin
            if (cur_x <= 10'(PLAT_HW + 1)) begin
              x_d[idx_q]   = 10'(PLAT_HW);
              dir_d[idx_q] = 1'b1;
            end else begin
              x_d[idx_q] = cur_x - 10'd1;
            end
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr_q <= LFSR_SEED;
      for (int i = 0; i < NUM_PLAT; i++) begin
        y_q[i] <= 11'(i * SPACING);
        x_q[i] <= 10'(PLAT_HW + ((i * 97 + 53) % RANGE));
      end
    end else begin
      lfsr_q <= lfsr_d;
      y_q    <= y_d;
      x_q    <= x_d;
    end
  end

`ifdef PLATFORM_FIELD_MOVING_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) dir_q <= '1;
    else       dir_q <= dir_d;
  end
`endif

  // |p - c| <= lim with p unsigned and c signed, both widened to 12 bits
  function automatic logic near(input logic [9:0] p, input logic [10:0] c, input logic [11:0] lim);
    logic [11:0] d;
    d = {2'b00, p} - {c[10], c};
    if (d[11]) d = -d;
    return (d <= lim);
  endfunction

  always_comb begin
    on_d   = 1'b0;
    pidx_d = '0;
    land_d = 1'b0;
    // descending scan so the lowest hitting index is the one that sticks
    for (int i = NUM_PLAT - 1; i >= 0; i--) begin
      if (!y_q[i][10] && near(bus.DrawX, {1'b0, x_q[i]}, 12'(PLAT_HW)) &&
          near(bus.DrawY, y_q[i], 12'(PLAT_HH))) begin
        on_d   = 1'b1;
        pidx_d = 5'(i);
      end
      if (!y_q[i][10] && near(bus.BallX, {1'b0, x_q[i]}, 12'(PLAT_HW)) &&
          near(bus.BallBottom, y_q[i], 12'(PLAT_HH))) begin
        land_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      on_q   <= 1'b0;
      pidx_q <= '0;
      land_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      on_q   <= on_d;
      pidx_q <= pidx_d;
      land_q <= land_d;
      done_q <= done_d;
    end
  end

  assign bus.platform_on = on_q;
  assign bus.plat_idx    = pidx_q;
  assign bus.land        = land_q;
  assign bus.update_done = done_q;

endmodule
